shell_sync_qualify: RTL

Stability qualifier for multi-bit buses that have crossed into the `clk` domain through a `shell_sync_regs` chain. Individual bits of a synchronized bus can land on different cycles, so the raw synchronizer output may briefly show mixed old/new values. This block passes a value to `dout` only after it has been constant for `STABLE_CYCLES` consecutive samples. It also flags each update with a one-cycle `change` strobe and keeps a saturating count of rejected (abandoned) candidate values.

---
 rtl/shell_sync_qualify.sv | 64 ++++++
 1 files changed

// File: rtl/shell_sync_qualify.sv
// Stability qualifier for a multi-bit bus that has already been synchronized into clk.
// A value reaches dout only after STABLE_CYCLES identical consecutive samples.
module shell_sync_qualify #(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic                change,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    logic din_diff;
    logic pending;
    logic commit;
    logic glitch;

    // A candidate is only "pending" when it would actually change the qualified output.
    assign din_diff = (din != cand);
    assign pending  = (cnt != '0) && (!dout_valid || (cand != dout));
    assign commit   = pending && (cnt == CNT_MAX);
    assign glitch   = din_diff && pending && (cnt < CNT_MAX);

    // NOTE: all state uses non-blocking assignments so every update reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (sclr) begin
            cand       <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            change     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            if (din_diff) begin
                cand <= din;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Commit uses the registered candidate, so a din move on this edge cannot block it.
            change <= commit;
            if (commit) begin
                dout       <= cand;
                dout_valid <= 1'b1;
            end

            if (glitch && (glitch_cnt != '1)) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end

endmodule
